// File: rtl/e1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : e1_pkg
// Description : Constants shared by the E1 transmit and receive framers, plus
//               a helper that builds the TS0 word for FAS/NFAS frames.
// Revision    : 1.0  initial release
// ============================================================================
package e1_pkg;

    localparam logic [6:0] FAS_PAT     = 7'b0011011;
    localparam logic [7:0] BITPERFRAME = 8'd255;
    localparam logic [4:0] NFAS_SA     = 5'b11111;
    localparam logic [7:0] AIS_WORD    = 8'hFF;
    localparam logic [4:0] TS_LAST     = 5'd31;

    // TS0 contents: even frames carry Si + FAS, odd frames carry Si, 1, A, Sa4..Sa8.
    function automatic logic [7:0] ts0_word(input logic       odd_frame,
                                            input logic       a_bit,
                                            input logic [6:0] fas);
        if (odd_frame) begin
            ts0_word = {1'b1, 1'b1, a_bit, NFAS_SA};
        end else begin
            ts0_word = {1'b1, fas};
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/e1txfifo.sv
`default_nettype none
// ============================================================================
// Module      : e1txfifo
// Description : Small synchronous byte FIFO feeding the E1 transmit framer.
//               Head word is presented combinationally on dout. Pops on an
//               empty FIFO and pushes on a full FIFO are ignored.
// Revision    : 1.0  initial release
// ============================================================================
module e1txfifo
    import e1_pkg::*;
#(
    parameter int WID       = 8,
    parameter int FIFODEPTH = 4
) (
    input  logic           clk2,
    input  logic           rst,
    input  logic           push,
    input  logic           pop,
    input  logic [WID-1:0] din,
    output logic [WID-1:0] dout,
    output logic           full,
    output logic           empty
);

    localparam int            AW       = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
    localparam int            CW       = $clog2(FIFODEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(FIFODEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFODEPTH);

    logic [WID-1:0] mem_q [FIFODEPTH];
    logic [WID-1:0] mem_d [FIFODEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           wr_en;
    logic           rd_en;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    // Next-state for storage, pointers and occupancy; simultaneous push/pop keeps the count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + CW'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CW'(1);
        end
    end

    // State registers; reset empties the FIFO but leaves the storage untouched.
    always_ff @(posedge clk2) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/e1_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : e1_tx_framer
// Description : E1 (G.704) transmit framer. Serialises TS0 (FAS/NFAS) and
//               TS1..TS31 payload from a byte FIFO, MSB first, with AIS and
//               underflow fill. Optional feature macro E1_TX_FRAMER_RAI_EN
//               adds the rai port driving the NFAS A bit (A=0 otherwise).
// Revision    : 1.0  initial release
// ============================================================================
module e1_tx_framer
    import e1_pkg::*;
#(
    parameter int         WID         = 8,
    parameter logic [6:0] FAS_PAT     = e1_pkg::FAS_PAT,
    parameter logic [7:0] BITPERFRAME = e1_pkg::BITPERFRAME,
    parameter int         FIFODEPTH   = 4
) (
    input  logic           clk2,
    input  logic           rst,
    input  logic [WID-1:0] datain,
    input  logic           divld,
    output logic           dirdy,
    input  logic           aisreq,
`ifdef E1_TX_FRAMER_RAI_EN
    input  logic           rai,
`endif
    output logic           serout,
    output logic           sof,
    output logic           undflw
);

    logic [7:0]     bitcnt_q, bitcnt_d;
    logic           fr_odd_q, fr_odd_d;
    logic [WID-1:0] shreg_q,  shreg_d;
    logic           undflw_q, undflw_d;
    logic [WID-1:0] word;
    logic           load;
    logic           ts0_next;
    logic           a_bit;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [WID-1:0] fifo_dout;

`ifdef E1_TX_FRAMER_RAI_EN
    assign a_bit = rai;
`else
    assign a_bit = 1'b0;
`endif

    // A word is loaded at the last bit of every timeslot; the load in TS31 is next frame's TS0.
    assign load     = (bitcnt_q[2:0] == 3'b111);
    assign ts0_next = (bitcnt_q[7:3] == TS_LAST);
    assign fifo_pop = load && !ts0_next;

    assign serout = shreg_q[WID-1];
    assign sof    = (bitcnt_q == 8'd0);
    assign undflw = undflw_q;
    assign dirdy  = !fifo_full;

    e1txfifo #(
        .WID       (WID),
        .FIFODEPTH (FIFODEPTH)
    ) u_fifo (
        .clk2  (clk2),
        .rst   (rst),
        .push  (divld),
        .pop   (fifo_pop),
        .din   (datain),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Bit counter, frame parity, transmit word mux and shift register next-state.
    always_comb begin
        bitcnt_d = (bitcnt_q == BITPERFRAME) ? 8'd0 : bitcnt_q + 8'd1;
        fr_odd_d = fr_odd_q;
        shreg_d  = {shreg_q[WID-2:0], 1'b1};
        undflw_d = 1'b0;
        word     = AIS_WORD;
        if (load) begin
            if (ts0_next) begin
                // Parity of the frame being started is the toggled value.
                fr_odd_d = !fr_odd_q;
                word     = ts0_word(!fr_odd_q, a_bit, FAS_PAT);
            end else if (fifo_empty) begin
                word     = AIS_WORD;
                undflw_d = !aisreq;
            end else begin
                word     = fifo_dout;
            end
            // AIS overrides everything; FIFO pop above still happens to hold alignment.
            if (aisreq) begin
                word = AIS_WORD;
            end
            shreg_d = word;
        end
    end

    // Framing registers; reset parks the counter so the first load is an even-frame TS0.
    always_ff @(posedge clk2) begin
        if (rst) begin
            bitcnt_q <= 8'd255;
            fr_odd_q <= 1'b1;
            shreg_q  <= {WID{1'b1}};
            undflw_q <= 1'b0;
        end else begin
            bitcnt_q <= bitcnt_d;
            fr_odd_q <= fr_odd_d;
            shreg_q  <= shreg_d;
            undflw_q <= undflw_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_e1_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_e1_tx_framer
// Description : Directed self-checking bench for e1_tx_framer. Captures whole
//               frames of serial output and compares timeslot bytes, sof and
//               underflow counts against hand-computed values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_e1_tx_framer;

    localparam logic [7:0] FAS_BYTE = 8'b10011011;
`ifdef E1_TX_FRAMER_RAI_EN
    localparam logic       A_EXP    = 1'b1;
`else
    localparam logic       A_EXP    = 1'b0;
`endif
    localparam logic [7:0] NFAS_BYTE = {2'b11, A_EXP, 5'b11111};

    localparam int M_IDLE  = 0;
    localparam int M_FEED  = 1;
    localparam int M_BURST = 2;
    localparam int M_AISPU = 3;

    logic       clk2;
    logic       rst;
    logic [7:0] datain;
    logic       divld;
    logic       dirdy;
    logic       aisreq;
`ifdef E1_TX_FRAMER_RAI_EN
    logic       rai;
`endif
    logic       serout;
    logic       sof;
    logic       undflw;

    int   nvec;
    int   nmis;
    logic bits [256];
    int   sofcnt;
    logic sof_at0;
    int   ufcnt;

    e1_tx_framer dut (
        .clk2   (clk2),
        .rst    (rst),
        .datain (datain),
        .divld  (divld),
        .dirdy  (dirdy),
        .aisreq (aisreq),
`ifdef E1_TX_FRAMER_RAI_EN
        .rai    (rai),
`endif
        .serout (serout),
        .sof    (sof),
        .undflw (undflw)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ts_byte(input int t);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < 8; k++) begin
            b = {b[6:0], bits[8*t + k]};
        end
        return b;
    endfunction

    function automatic int ones_cnt();
        int n;
        n = 0;
        for (int k = 0; k < 256; k++) begin
            if (bits[k]) n++;
        end
        return n;
    endfunction

    task automatic do_reset();
        @(negedge clk2);
        rst    = 1'b1;
        divld  = 1'b0;
        aisreq = 1'b0;
        datain = 8'h00;
        repeat (3) @(negedge clk2);
        chk("rst_serout", {31'd0, serout}, 32'd1);
        chk("rst_sof",    {31'd0, sof},    32'd0);
        chk("rst_undflw", {31'd0, undflw}, 32'd0);
        chk("rst_dirdy",  {31'd0, dirdy},  32'd1);
        rst = 1'b0;
    endtask

    // Captures one frame starting at bitcnt==0; drives inputs for the following cycle.
    task automatic run_frame(input int mode);
        logic fidx;
        logic rdy_prev;
        logic [7:0] burst [5];
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
        burst[3] = 8'h44; burst[4] = 8'h55;
        fidx     = 1'b0;
        rdy_prev = 1'b0;
        sofcnt   = 0;
        sof_at0  = 1'b0;
        ufcnt    = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk2);
            bits[i] = serout;
            if (sof) begin
                sofcnt++;
                if (i == 0) sof_at0 = 1'b1;
            end
            if (undflw) ufcnt++;
            case (mode)
                M_FEED: begin
                    if (divld && rdy_prev) fidx = ~fidx;
                    divld    = 1'b1;
                    datain   = fidx ? 8'h3C : 8'hA5;
                    rdy_prev = dirdy;
                end
                M_BURST: begin
                    if (i == 8)  chk("burst_rdy_before", {31'd0, dirdy}, 32'd1);
                    if (i == 12) chk("burst_full",       {31'd0, dirdy}, 32'd0);
                    divld  = (i >= 8 && i <= 12);
                    datain = (i >= 8 && i <= 12) ? burst[i-8] : 8'h00;
                end
                M_AISPU: begin
                    divld  = (i < 4);
                    datain = 8'h60 + 8'(i);
                end
                default: begin
                    divld = 1'b0;
                end
            endcase
        end
    endtask

    initial begin
        nvec   = 0;
        nmis   = 0;
        rst    = 1'b1;
        divld  = 1'b0;
        aisreq = 1'b0;
        datain = 8'h00;
`ifdef E1_TX_FRAMER_RAI_EN
        rai    = 1'b1;
`endif

        // Idle after reset: FAS then NFAS, all payload underflows.
        do_reset();
        run_frame(M_IDLE);
        chk("idle_ts0_fas", ts_byte(0), FAS_BYTE);
        chk("idle_sof_at0", {31'd0, sof_at0}, 32'd1);
        chk("idle_sofcnt",  sofcnt, 1);
        chk("idle_ts1",     ts_byte(1), 8'hFF);
        chk("idle_uf",      ufcnt, 31);
        run_frame(M_IDLE);
        chk("idle_ts0_nfas", ts_byte(0), NFAS_BYTE);
        chk("idle_uf2",      ufcnt, 31);

        // Continuous A5/3C feed.
        do_reset();
        run_frame(M_FEED);
        chk("feed_ts0",  ts_byte(0),  FAS_BYTE);
        chk("feed_ts1",  ts_byte(1),  8'hA5);
        chk("feed_ts2",  ts_byte(2),  8'h3C);
        chk("feed_ts3",  ts_byte(3),  8'hA5);
        chk("feed_ts31", ts_byte(31), 8'hA5);
        chk("feed_uf",   ufcnt, 0);

        // Burst of five into an empty FIFO: fifth dropped, order kept.
        do_reset();
        run_frame(M_BURST);
        chk("burst_ts1", ts_byte(1), 8'hFF);
        chk("burst_ts2", ts_byte(2), 8'h11);
        chk("burst_ts3", ts_byte(3), 8'h22);
        chk("burst_ts4", ts_byte(4), 8'h33);
        chk("burst_ts5", ts_byte(5), 8'h44);
        chk("burst_ts6", ts_byte(6), 8'hFF);
        chk("burst_uf",  ufcnt, 27);

        // AIS for two frames; bytes pushed during AIS are drained and discarded.
        aisreq = 1'b1;
        run_frame(M_AISPU);
        chk("ais1_ones", ones_cnt(), 256);
        chk("ais1_uf",   ufcnt, 0);
        divld = 1'b0;
        run_frame(M_IDLE);
        chk("ais2_ones", ones_cnt(), 256);
        chk("ais2_uf",   ufcnt, 0);
        chk("ais2_sof",  sofcnt, 1);
        aisreq = 1'b0;
        run_frame(M_IDLE);
        chk("post_ais_ts0", ts_byte(0), NFAS_BYTE);
        chk("post_ais_ts1", ts_byte(1), 8'hFF);
        chk("post_ais_uf",  ufcnt, 31);

        // Mid-frame reset at bitcnt 100 with a full FIFO.
        do_reset();
        for (int j = 0; j <= 100; j++) begin
            @(negedge clk2);
            divld  = (j < 100);
            datain = 8'h77;
            if (j == 100) rst = 1'b1;
        end
        @(negedge clk2);
        chk("mid_rst_dirdy",  {31'd0, dirdy},  32'd1);
        chk("mid_rst_serout", {31'd0, serout}, 32'd1);
        chk("mid_rst_sof",    {31'd0, sof},    32'd0);
        rst = 1'b0;
        run_frame(M_IDLE);
        chk("mid_ts0_fas", ts_byte(0), FAS_BYTE);
        chk("mid_sof_at0", {31'd0, sof_at0}, 32'd1);
        chk("mid_ts1",     ts_byte(1), 8'hFF);
        chk("mid_uf",      ufcnt, 31);
        run_frame(M_IDLE);
        chk("mid_nfas",    ts_byte(0), NFAS_BYTE);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
`default_nettype wire
